// File: rtl/alu_issue_ctrl.sv
// Multi-cycle decode/issue sequencer: accepts a MIPS instruction, reads rs/rt, drives the ALU, writes back.
// Optional macro ALU_ILLEGAL_TRAP_EN adds an Illegal retire flag for unsupported encodings.
module alu_issue_ctrl #(
  parameter int REG_AW = 5,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Instr_Valid,
  output logic              Instr_Ready,
  input  logic [31:0]       Instruction_In,
  output logic [REG_AW-1:0] Rf_Raddr1,
  output logic [REG_AW-1:0] Rf_Raddr2,
  input  logic [DW-1:0]     Rf_Rdata1,
  input  logic [DW-1:0]     Rf_Rdata2,
  output logic [DW-1:0]     Data1,
  output logic [DW-1:0]     Data2,
  output logic [31:0]       Instruction,
  output logic [3:0]        Opcode_ALU,
  input  logic [DW-1:0]     Result,
  output logic              Rf_We,
  output logic [REG_AW-1:0] Rf_Waddr,
  output logic [DW-1:0]     Rf_Wdata,
`ifdef ALU_ILLEGAL_TRAP_EN
  output logic              Done,
  output logic              Illegal
`else
  output logic              Done
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      state, state_next;
  logic [31:0] rd_src;
  logic        dec_legal, dec_shift, dec_itype;
  logic [3:0]  dec_op;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    Instr_Ready = 1'b0;
    unique case (state)
      IDLE: begin
        Instr_Ready = 1'b1;
        if (Instr_Valid) state_next = READ;
      end
      READ:    state_next = EXEC;
      EXEC:    state_next = WB;
      default: state_next = IDLE;
    endcase
  end

  // The register file is synchronous, so the source addresses are presented in the accept
  // cycle as well; the read data is then stable during READ and captured on entry to EXEC.
  always_comb begin
    rd_src = Instruction;
    if (state == IDLE) rd_src = Instr_Valid ? Instruction_In : 32'h0;
  end

  assign Rf_Raddr1 = REG_AW'(rd_src[25:21]);
  assign Rf_Raddr2 = REG_AW'(rd_src[20:16]);

  always_comb begin
    dec_legal = 1'b1;
    dec_shift = 1'b0;
    dec_itype = 1'b0;
    dec_op    = 4'b0000;
    if (Instruction[31:26] == 6'h00) begin
      unique case (Instruction[5:0])
        6'h20:   dec_op = 4'b0000;
        6'h22:   dec_op = 4'b0001;
        6'h21:   dec_op = 4'b0010;
        6'h23:   dec_op = 4'b0011;
        6'h24:   dec_op = 4'b0110;
        6'h25:   dec_op = 4'b0111;
        6'h00:   begin dec_op = 4'b1010; dec_shift = 1'b1; end
        6'h02:   begin dec_op = 4'b1011; dec_shift = 1'b1; end
        6'h2A:   dec_op = 4'b1100;
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_itype = 1'b1;
      unique case (Instruction[31:26])
        6'h08:   dec_op = 4'b0100;
        6'h09:   dec_op = 4'b0101;
        6'h0C:   dec_op = 4'b1000;
        6'h0D:   dec_op = 4'b1001;
        6'h0A:   dec_op = 4'b1101;
        default: dec_legal = 1'b0;
      endcase
    end
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  logic legal_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Instruction <= '0;
      Data1       <= '0;
      Data2       <= '0;
      Opcode_ALU  <= '0;
      Rf_Waddr    <= '0;
      Rf_Wdata    <= '0;
      Rf_We       <= 1'b0;
      Done        <= 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
      legal_q     <= 1'b1;
      Illegal     <= 1'b0;
`endif
    end else begin
      Rf_We <= 1'b0;
      Done  <= 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
      Illegal <= 1'b0;
`endif
      if (Instr_Valid && Instr_Ready) Instruction <= Instruction_In;

      if (state == READ) begin
        Opcode_ALU <= dec_op;
        Data1      <= dec_shift ? Rf_Rdata2 : Rf_Rdata1;
        if (dec_itype)      Data2 <= DW'(Instruction[15:0]);
        else if (dec_shift) Data2 <= DW'(Instruction[10:6]);
        else                Data2 <= Rf_Rdata2;
        // Unsupported encodings target register 0, which suppresses the write-back.
        if (!dec_legal)     Rf_Waddr <= '0;
        else if (dec_itype) Rf_Waddr <= REG_AW'(Instruction[20:16]);
        else                Rf_Waddr <= REG_AW'(Instruction[15:11]);
`ifdef ALU_ILLEGAL_TRAP_EN
        legal_q <= dec_legal;
`endif
      end

      if (state == EXEC) begin
        Rf_Wdata <= Result;
        Rf_We    <= (Rf_Waddr != '0);
        Done     <= 1'b1;
`ifdef ALU_ILLEGAL_TRAP_EN
        Illegal  <= !legal_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized instructions checked against an instruction-level reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction_in;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [31:0] data1, data2, instruction;
  logic [3:0]  opcode_alu;
  logic [31:0] result;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        done;
  logic        illegal;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.REG_AW(5), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .Instr_Valid(instr_valid), .Instr_Ready(instr_ready), .Instruction_In(instruction_in),
    .Rf_Raddr1(rf_raddr1), .Rf_Raddr2(rf_raddr2), .Rf_Rdata1(rf_rdata1), .Rf_Rdata2(rf_rdata2),
    .Data1(data1), .Data2(data2), .Instruction(instruction), .Opcode_ALU(opcode_alu),
    .Result(result), .Rf_We(rf_we), .Rf_Waddr(rf_waddr), .Rf_Wdata(rf_wdata),
`ifdef ALU_ILLEGAL_TRAP_EN
    .Done(done), .Illegal(illegal)
`else
    .Done(done)
`endif
  );

`ifndef ALU_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  // Register file contents; synchronous read, writes are not applied so operands stay known.
  logic [31:0] regs [32];
  always @(posedge clk) begin
    rf_rdata1 <= regs[rf_raddr1];
    rf_rdata2 <= regs[rf_raddr2];
  end

  // Combinational ALU; immediates are sign-extended from the latched instruction where MIPS requires it.
  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, b, ins);
    logic [31:0] sx;
    sx = {{16{ins[15]}}, ins[15:0]};
    case (op)
      4'b0000, 4'b0010: return a + b;
      4'b0001, 4'b0011: return a - b;
      4'b0110: return a & b;
      4'b0111: return a | b;
      4'b1010: return a << b[4:0];
      4'b1011: return a >> b[4:0];
      4'b1100: return {31'b0, $signed(a) < $signed(b)};
      4'b0100, 4'b0101: return a + sx;
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1101: return {31'b0, $signed(a) < $signed(sx)};
      default: return 32'h0;
    endcase
  endfunction

  always_comb result = alu(opcode_alu, data1, data2, instruction);

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic [31:0] d1, d2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        illegal;
    logic        chk_data;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Instruction-level model: what the MIPS instruction should do to the architectural state.
  function automatic vec_t ref_model(input logic [31:0] w);
    vec_t        e;
    logic [31:0] a, b, immz, imms;
    logic [4:0]  shamt;
    logic        bad;
    a     = regs[w[25:21]];
    b     = regs[w[20:16]];
    immz  = {16'h0, w[15:0]};
    imms  = {{16{w[15]}}, w[15:0]};
    shamt = w[10:6];
    bad   = 1'b0;
    e.instr = w; e.op = 4'b0000; e.d1 = a; e.d2 = b; e.wdata = 32'h0;
    e.chk_data = 1'b1; e.illegal = 1'b0;
    if (w[31:26] == 6'h00) begin
      e.waddr = w[15:11];
      case (w[5:0])
        6'h20: begin e.op = 4'b0000; e.wdata = a + b; end
        6'h22: begin e.op = 4'b0001; e.wdata = a - b; end
        6'h21: begin e.op = 4'b0010; e.wdata = a + b; end
        6'h23: begin e.op = 4'b0011; e.wdata = a - b; end
        6'h24: begin e.op = 4'b0110; e.wdata = a & b; end
        6'h25: begin e.op = 4'b0111; e.wdata = a | b; end
        6'h00: begin e.op = 4'b1010; e.d1 = b; e.d2 = {27'h0, shamt}; e.wdata = b << shamt; end
        6'h02: begin e.op = 4'b1011; e.d1 = b; e.d2 = {27'h0, shamt}; e.wdata = b >> shamt; end
        6'h2A: begin e.op = 4'b1100; e.wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        default: bad = 1'b1;
      endcase
    end else begin
      e.waddr = w[20:16];
      e.d2    = immz;
      case (w[31:26])
        6'h08: begin e.op = 4'b0100; e.wdata = a + imms; end
        6'h09: begin e.op = 4'b0101; e.wdata = a + imms; end
        6'h0C: begin e.op = 4'b1000; e.wdata = a & immz; end
        6'h0D: begin e.op = 4'b1001; e.wdata = a | immz; end
        6'h0A: begin e.op = 4'b1101; e.wdata = ($signed(a) < $signed(imms)) ? 32'd1 : 32'd0; end
        default: bad = 1'b1;
      endcase
    end
    if (bad) begin
      e.op = 4'b0000; e.chk_data = 1'b0; e.illegal = 1'b1; e.waddr = 5'd0;
    end
    e.we = !bad && (e.waddr != 5'd0);
    return e;
  endfunction

  // Issues one instruction from an idle negedge and checks every stage; ends on the idle negedge.
  task automatic issue(input vec_t v, input string tag);
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      check({tag, " ready_timeout"}, 32'(instr_ready), 32'd1);
      return;
    end
    instr_valid    = 1'b1;
    instruction_in = v.instr;
    @(negedge clk);
    instr_valid = 1'b0;
    check({tag, " busy_ready"}, 32'(instr_ready), 32'd0);
    check({tag, " raddr1"}, 32'(rf_raddr1), 32'(v.instr[25:21]));
    @(negedge clk);
    check({tag, " opcode"}, 32'(opcode_alu), 32'(v.op));
    if (v.chk_data) begin
      check({tag, " data1"}, data1, v.d1);
      check({tag, " data2"}, data2, v.d2);
    end
    check({tag, " exec_done"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, " wb_done"}, 32'(done), 32'd1);
    check({tag, " wb_we"}, 32'(rf_we), 32'(v.we));
    if (v.chk_data) begin
      check({tag, " waddr"}, 32'(rf_waddr), 32'(v.waddr));
      check({tag, " wdata"}, rf_wdata, v.wdata);
    end
`ifdef ALU_ILLEGAL_TRAP_EN
    check({tag, " illegal"}, 32'(illegal), 32'(v.illegal));
`endif
    @(negedge clk);
    check({tag, " idle_done"}, 32'(done), 32'd0);
    check({tag, " idle_we"}, 32'(rf_we), 32'd0);
    check({tag, " idle_ready"}, 32'(instr_ready), 32'd1);
  endtask

  vec_t vecs [9];

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instruction_in = 32'h0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
    regs[0] = 32'h0; regs[1] = 32'd5; regs[2] = 32'd7;

    vecs[0] = '{32'h00221820, 4'b0000, 32'd5, 32'd7,      1'b1, 5'd3, 32'd12,   1'b0, 1'b1};
    vecs[1] = '{32'h2024FFFF, 4'b0100, 32'd5, 32'h0000FFFF, 1'b1, 5'd4, 32'd4,  1'b0, 1'b1};
    vecs[2] = '{32'h00022900, 4'b1010, 32'd7, 32'd4,      1'b1, 5'd5, 32'h70,   1'b0, 1'b1};
    vecs[3] = '{32'h00220020, 4'b0000, 32'd5, 32'd7,      1'b0, 5'd0, 32'd12,   1'b0, 1'b1};
    vecs[4] = '{32'h00413022, 4'b0001, 32'd7, 32'd5,      1'b1, 5'd6, 32'd2,    1'b0, 1'b1};
    vecs[5] = '{32'h0022382A, 4'b1100, 32'd5, 32'd7,      1'b1, 5'd7, 32'd1,    1'b0, 1'b1};
    vecs[6] = '{32'h344800F0, 4'b1001, 32'd7, 32'h000000F0, 1'b1, 5'd8, 32'hF7, 1'b0, 1'b1};
    vecs[7] = '{32'hFC000000, 4'b0000, 32'd0, 32'd0,      1'b0, 5'd0, 32'd0,    1'b1, 1'b0};
    vecs[8] = '{32'h0022183F, 4'b0000, 32'd0, 32'd0,      1'b0, 5'd0, 32'd0,    1'b1, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst ready", 32'(instr_ready), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst we", 32'(rf_we), 32'd0);
    check("rst opcode", 32'(opcode_alu), 32'd0);
    check("rst data1", data1, 32'd0);
    check("rst data2", data2, 32'd0);
    check("rst wdata", rf_wdata, 32'd0);
    check("rst waddr", 32'(rf_waddr), 32'd0);
    check("rst instruction", instruction, 32'd0);
    check("rst raddr1", 32'(rf_raddr1), 32'd0);
    check("rst illegal", 32'(illegal), 32'd0);

    for (int i = 0; i < 9; i++) issue(vecs[i], $sformatf("vec%0d", i));

    // Valid held high: accepts must land exactly every fourth cycle.
    begin
      int acc[$];
      int dones = 0;
      instr_valid = 1'b1; instruction_in = 32'h00221820;
      for (int i = 0; i < 12; i++) begin
        if (instr_ready) acc.push_back(i);
        @(negedge clk);
        if (done) dones++;
      end
      instr_valid = 1'b0;
      check("b2b accepts", 32'(acc.size()), 32'd3);
      if (acc.size() == 3) begin
        check("b2b first", 32'(acc[0]), 32'd0);
        check("b2b gap1", 32'(acc[1] - acc[0]), 32'd4);
        check("b2b gap2", 32'(acc[2] - acc[1]), 32'd4);
      end
      check("b2b dones", 32'(dones), 32'd3);
    end

    // Reset during EXEC aborts the instruction: no write, no retire.
    begin
      int bad = 0;
      @(negedge clk);
      instr_valid = 1'b1; instruction_in = 32'h00221820;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) begin
        @(negedge clk);
        if (rf_we || done) bad++;
      end
      reset = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (rf_we || done) bad++;
      end
      check("abort no_pulse", 32'(bad), 32'd0);
      check("abort ready", 32'(instr_ready), 32'd1);
      check("abort data1", data1, 32'd0);
      check("abort opcode", 32'(opcode_alu), 32'd0);
    end

    // Randomized instructions against the reference model.
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    for (int t = 0; t < 200; t++) begin
      logic [31:0] w;
      int          k;
      logic [5:0]  functs [9];
      logic [5:0]  iops [5];
      functs = '{6'h20, 6'h22, 6'h21, 6'h23, 6'h24, 6'h25, 6'h00, 6'h02, 6'h2A};
      iops   = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A};
      w = $urandom;
      k = $urandom_range(0, 15);
      if (k < 9) begin
        w[31:26] = 6'h00;
        w[5:0]   = functs[k];
      end else if (k < 14) begin
        w[31:26] = iops[k - 9];
      end else if (k == 14) begin
        w[31:26] = 6'h00;
        w[5:0]   = 6'h3F;
      end else begin
        w[31:26] = 6'h3F;
      end
      issue(ref_model(w), $sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
